// File: rtl/prog_ram_loader.sv
// Serial loader: byte stream frames -> 18-bit words written into a 1Kx18 program RAM.
// Optional inter-byte idle timeout is enabled by defining LOADER_TIMEOUT_EN.
module prog_ram_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [9:0]  ADDR,
  output logic [15:0] DI,
  output logic [1:0]  DIP,
  output logic        EN,
  output logic        WE,
  output logic        CPU_RESET,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_H, S_CNT_L, S_B0, S_B1, S_B2, S_WRITE, S_CSUM
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [9:0]  last_q, last_d;
  logic [7:0]  sum_q, sum_d, sum_add;
  logic [1:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [9:0]  addr_d;
  logic [15:0] di_d;
  logic [1:0]  dip_d;
  logic        we_d, cpu_d, done_d, err_d, rdy_d;
  logic        accept;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  assign accept  = RX_VALID & RX_READY;
  assign sum_add = sum_q + RX_DATA;

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    sum_d   = sum_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    addr_d  = ADDR;
    di_d    = DI;
    dip_d   = DIP;
    we_d    = 1'b0;
    cpu_d   = CPU_RESET;
    done_d  = 1'b0;
    err_d   = ERR;

    case (state_q)
      S_IDLE: if (accept && RX_DATA == SYNC_BYTE) begin
        state_d = S_CNT_H;
        cpu_d   = 1'b1;
        err_d   = 1'b0;
        idx_d   = '0;
        sum_d   = '0;
      end
      S_CNT_H: if (accept) begin
        if (RX_DATA[7:2] != 6'd0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          last_d[9:8] = RX_DATA[1:0];
          sum_d       = sum_add;
          state_d     = S_CNT_L;
        end
      end
      S_CNT_L: if (accept) begin
        last_d[7:0] = RX_DATA;
        sum_d       = sum_add;
        state_d     = S_B0;
      end
      S_B0: if (accept) begin
        b0_d    = RX_DATA[1:0];
        sum_d   = sum_add;
        state_d = S_B1;
      end
      S_B1: if (accept) begin
        b1_d    = RX_DATA;
        sum_d   = sum_add;
        state_d = S_B2;
      end
      S_B2: if (accept) begin
        sum_d   = sum_add;
        addr_d  = idx_q;
        di_d    = {b1_q, RX_DATA};
        dip_d   = b0_q;
        we_d    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = 10'(idx_q + 10'd1);
        state_d = (idx_q == last_q) ? S_CSUM : S_B0;
      end
      S_CSUM: if (accept) begin
        if (sum_add == 8'd0) begin
          done_d = 1'b1;
          cpu_d  = 1'b0;
        end else begin
          err_d  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    // Idle watchdog: only ticks while waiting for a byte mid-frame
    tcnt_d = tcnt_q;
    if (state_q == S_IDLE || accept) begin
      tcnt_d = '0;
    end else if (state_q != S_WRITE) begin
      if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt_d  = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        tcnt_d = TW'(tcnt_q + 1'b1);
      end
    end
`endif

    rdy_d = (state_d != S_WRITE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      sum_q     <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      RX_READY  <= 1'b0;
      ADDR      <= '0;
      DI        <= '0;
      DIP       <= '0;
      EN        <= 1'b0;
      WE        <= 1'b0;
      CPU_RESET <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      sum_q     <= sum_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      RX_READY  <= rdy_d;
      ADDR      <= addr_d;
      DI        <= di_d;
      DIP       <= dip_d;
      EN        <= we_d;
      WE        <= we_d;
      CPU_RESET <= cpu_d;
      DONE      <= done_d;
      ERR       <= err_d;
`ifdef LOADER_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_ram_loader.sv
// Scoreboard bench for prog_ram_loader: expected RAM writes queued as frames are sent.
module tb_prog_ram_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [9:0]  ADDR;
  logic [15:0] DI;
  logic [1:0]  DIP;
  logic        EN, WE, CPU_RESET, DONE, ERR;

  int n_cmp = 0;
  int n_bad = 0;

  logic [27:0] exp_q[$];
  logic [17:0] wbuf[1024];
  int  we_cnt = 0, done_cnt = 0, cyc = 0, last_we_cyc = 0;
  bit  chk_gap = 0, have_prev = 0, chk_ready = 0;

  always #5 CLK = ~CLK;

  prog_ram_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .ADDR(ADDR), .DI(DI), .DIP(DIP), .EN(EN), .WE(WE),
    .CPU_RESET(CPU_RESET), .DONE(DONE), .ERR(ERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge CLK) begin
    logic [27:0] e;
    cyc++;
    if (DONE) done_cnt++;
    if (chk_ready) check("ready_vs_we", 32'(RX_READY), 32'(!WE));
    if (WE) begin
      we_cnt++;
      check("we_en", 32'(EN), 32'd1);
      if (chk_gap && have_prev) check("we_gap", 32'(cyc - last_we_cyc), 32'd4);
      have_prev   = 1;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(WE), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", 32'(ADDR), 32'(e[27:18]));
        check("we_word", 32'({DIP, DI}), 32'(e[17:0]));
      end
    end
  end

  // Present a byte and hold it until accepted; called at a falling edge
  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    while (!RX_READY && budget < 100) begin
      @(negedge CLK);
      budget++;
    end
    if (!RX_READY) check("rx_ready_timeout", 32'(RX_READY), 32'd1);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_VALID = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input int n, input logic [7:0] csum_err);
    logic [9:0] c;
    logic [7:0] s, b0, b1, b2;
    c = 10'(n - 1);
    s = 8'(c[9:8]) + c[7:0];
    send_byte(8'hA5);
    send_byte(8'(c[9:8]));
    check("cpu_reset_in_frame", 32'(CPU_RESET), 32'd1);
    send_byte(c[7:0]);
    for (int i = 0; i < n; i++) begin
      b0 = {6'b101100, wbuf[i][17:16]};
      b1 = wbuf[i][15:8];
      b2 = wbuf[i][7:0];
      s  = s + b0 + b1 + b2;
      send_byte(b0);
      send_byte(b1);
      exp_q.push_back({10'(i), wbuf[i]});
      send_byte(b2);
    end
    send_byte(8'(8'd0 - s) + csum_err);
    RX_VALID = 1'b0;
  endtask

  initial begin
    int d0, w0;
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(RX_READY), 32'd0);
    check("rst_we", 32'({EN, WE}), 32'd0);
    check("rst_outs", 32'({CPU_RESET, DONE, ERR}), 32'd0);
    check("rst_addr", 32'({ADDR, DIP, DI}), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("ready_after_rst", 32'(RX_READY), 32'd1);

    // Non-sync bytes are ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(3);
    check("nosync_we", 32'(we_cnt), 32'd0);
    check("nosync_cpu", 32'(CPU_RESET), 32'd0);
    check("nosync_done", 32'(done_cnt), 32'd0);
    check("nosync_ready", 32'(RX_READY), 32'd1);

    // Good two-word frame
    wbuf[0] = 18'h12345;
    wbuf[1] = 18'h2ABCD;
    send_frame(2, 8'd0);
    idle(3);
    check("good_done", 32'(done_cnt), 32'd1);
    check("good_cpu", 32'(CPU_RESET), 32'd0);
    check("good_err", 32'(ERR), 32'd0);
    check("good_writes", 32'(we_cnt), 32'd2);

    // Bad checksum, then recovery
    send_frame(2, 8'd1);
    idle(3);
    check("badcs_writes", 32'(we_cnt), 32'd4);
    check("badcs_err", 32'(ERR), 32'd1);
    check("badcs_cpu", 32'(CPU_RESET), 32'd1);
    check("badcs_done", 32'(done_cnt), 32'd1);
    send_frame(2, 8'd0);
    idle(3);
    check("recover_err", 32'(ERR), 32'd0);
    check("recover_cpu", 32'(CPU_RESET), 32'd0);
    check("recover_done", 32'(done_cnt), 32'd2);

    // Illegal count high byte
    w0 = we_cnt;
    send_byte(8'hA5);
    send_byte(8'h04);
    idle(3);
    check("cnth_err", 32'(ERR), 32'd1);
    check("cnth_cpu", 32'(CPU_RESET), 32'd1);
    check("cnth_we", 32'(we_cnt), 32'(w0));

    // Full 1024-word frame, valid held high, with in-frame sync-valued data
    for (int i = 0; i < 1024; i++) wbuf[i] = 18'($urandom);
    wbuf[3] = 18'h0A5A5;
    w0 = we_cnt;
    d0 = done_cnt;
    have_prev = 0;
    chk_gap   = 1;
    chk_ready = 1;
    send_frame(1024, 8'd0);
    idle(3);
    chk_gap   = 0;
    chk_ready = 0;
    check("full_writes", 32'(we_cnt - w0), 32'd1024);
    check("full_last_addr", 32'(ADDR), 32'd1023);
    check("full_done", 32'(done_cnt - d0), 32'd1);
    check("full_cpu", 32'(CPU_RESET), 32'd0);
    check("full_err", 32'(ERR), 32'd0);

    // Reset while waiting for B1 of word 5
    for (int i = 0; i < 10; i++) wbuf[i] = 18'(i * 18'h1111 + 18'h00077);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h09);
    for (int i = 0; i < 5; i++) begin
      send_byte({6'd0, wbuf[i][17:16]});
      send_byte(wbuf[i][15:8]);
      exp_q.push_back({10'(i), wbuf[i]});
      send_byte(wbuf[i][7:0]);
    end
    send_byte(8'h01);
    RX_DATA = 8'h22;
    while (!RX_READY) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_ready", 32'(RX_READY), 32'd0);
    check("midrst_outs", 32'({EN, WE, CPU_RESET, DONE, ERR}), 32'd0);
    check("midrst_addr", 32'({ADDR, DIP, DI}), 32'd0);
    RST = 1'b0;
    idle(2);
    wbuf[0] = 18'h3FFFF;
    send_frame(1, 8'd0);
    idle(3);
    check("post_rst_cpu", 32'(CPU_RESET), 32'd0);
    check("post_rst_addr", 32'({ADDR, DIP, DI}), 32'h3FFFF);

`ifdef LOADER_TIMEOUT_EN
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(20);
    check("timeout_err", 32'(ERR), 32'd1);
    check("timeout_cpu", 32'(CPU_RESET), 32'd1);
    send_frame(1, 8'd0);
    idle(3);
    check("timeout_recover", 32'({CPU_RESET, ERR}), 32'd0);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_ram_loader.md
Name: prog_ram_loader

Overview:
- Serial program loader sitting directly upstream of the 1Kx18 program block RAM port used as KCPSM3 instruction store.
- Consumes a byte stream (valid/ready, e.g. from UART RX FIFO), assembles 18-bit instruction words and writes them sequentially into the RAM via its ADDR/DI/DIP/EN/WE pins.
- Holds the processor in reset while a load is in progress and releases it only on a checksum-verified frame.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, inter-byte idle limit in CLK cycles (used only with LOADER_TIMEOUT_EN).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA valid; sender holds data stable until accepted.
- RX_READY  out  1  loader accepts byte when RX_VALID & RX_READY.
- ADDR  out  10  RAM word address.
- DI  out  16  RAM data word.
- DIP  out  2  RAM parity bits (instruction bits 17:16).
- EN  out  1  RAM enable; pulsed together with WE.
- WE  out  1  RAM write enable, one-cycle pulse per word.
- CPU_RESET  out  1  processor reset request.
- DONE  out  1  one-cycle pulse on good frame.
- ERR  out  1  sticky error flag.

Behaviour:
- Frame: SYNC_BYTE, CNT_H, CNT_L, N x {B0,B1,B2}, CSUM. Word count N = {CNT_H[1:0],CNT_L}+1 (1..1024). B0[1:0]->DIP, B1->DI[15:8], B2->DI[7:0]; B0[7:2] ignored.
- Checksum: 8-bit sum of CNT_H, CNT_L, all payload bytes and CSUM must equal 8'h00 (mod 256).
- States: IDLE, CNT_H, CNT_L, B0, B1, B2, WRITE, CSUM.
- IDLE: RX_READY=1; bytes other than SYNC_BYTE are discarded; SYNC_BYTE -> CNT_H, CPU_RESET<=1, ERR<=0, word index<=0, running sum<=0.
- CNT_H: CNT_H[7:2]!=0 -> ERR<=1, back to IDLE, CPU_RESET stays 1. Else -> CNT_L.
- CNT_L -> B0 -> B1 -> B2, one accepted byte each.
- B2 accept -> WRITE: exactly one cycle with EN=WE=1, RX_READY=0, ADDR=word index, DI/DIP=assembled word. Then index+1; if the written word was word N-1 -> CSUM, else -> B0.
- CSUM accept: sum==0 -> DONE pulse (1 cycle), CPU_RESET<=0, IDLE. Sum!=0 -> ERR<=1, CPU_RESET stays 1, IDLE.
- RX_READY=1 in every receive state, 0 in WRITE and during reset. No byte is lost: RX_VALID during WRITE waits.
- EN/WE=0 outside WRITE; ADDR/DI/DIP hold last value outside WRITE.
- Max throughput: 4 cycles per word when RX_VALID is continuously high.
- ADDR never wraps within a frame (N<=1024); index 1023 is last possible write.
- A SYNC_BYTE inside a frame is data, not a restart.
- Reset values: RX_READY=0 (1 from first cycle after RST), ADDR=0, DI=0, DIP=0, EN=0, WE=0, CPU_RESET=0, DONE=0, ERR=0, state IDLE.
- RST mid-frame: immediate abort to IDLE with all reset values; RAM contents partially overwritten, no rollback.
- After ERR, CPU_RESET remains 1 until a good frame completes or RST.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- Defined: counter cleared on every accepted byte and in IDLE; counts in any non-IDLE receive state. Reaching TIMEOUT_CYCLES -> ERR<=1, IDLE, CPU_RESET stays 1.
- Undefined: no counter; loader waits indefinitely mid-frame.

Test Plan:
- Reset, then bytes 00,FF, no sync -> no WE, CPU_RESET=0, RX_READY=1, DONE=0.
- Frame A5,00,01 (N=2), words 01 23 45 / 02 AB CD, CSUM=8'h? computed so sum=0 -> WE at ADDR 0 (DIP=1,DI=2345), ADDR 1 (DIP=2,DI=ABCD), DONE pulse, CPU_RESET 1->0.
- Same frame with CSUM+1 -> both writes occur, ERR=1, CPU_RESET stays 1, no DONE; then good frame -> ERR=0, CPU_RESET=0.
- CNT_H=04 after sync -> ERR=1, IDLE, no WE.
- N=1024 with RX_VALID held high -> last WE at ADDR 1023, 4 cycles/word, RX_READY low only in WRITE cycles.
- RST asserted during B1 of word 5 -> next cycle all outputs at reset values; with LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, stall 16 cycles after CNT_L -> ERR=1, IDLE.
